// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the M-extension multiply/divide sequencer.
package muldiv_sequencer_pkg;

  typedef logic [2:0] funct3_t;

  localparam funct3_t F3_MUL    = 3'b000;
  localparam funct3_t F3_MULH   = 3'b001;
  localparam funct3_t F3_MULHSU = 3'b010;
  localparam funct3_t F3_MULHU  = 3'b011;
  localparam funct3_t F3_DIV    = 3'b100;
  localparam funct3_t F3_DIVU   = 3'b101;
  localparam funct3_t F3_REM    = 3'b110;
  localparam funct3_t F3_REMU   = 3'b111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // DIV/DIVU/REM/REMU all live in the upper half of the funct3 space.
  function automatic logic is_div_op(funct3_t f3);
    return f3[2];
  endfunction

  // Within the divide group the unsigned variants have funct3[0] set.
  function automatic logic is_signed_div(funct3_t f3);
    return ~f3[0];
  endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module muldiv_sequencer_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quot_next
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // rem < divisor always holds, so the shifted trial fits in XLEN+1 bits and
  // the MSB of the difference is a clean "borrow" flag.
  assign trial     = {rem, quot[XLEN-1]};
  assign diff      = trial - {1'b0, divisor};
  assign rem_next  = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
  assign quot_next = {quot[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit with its sequencing FSM; stalls EX while busy.
//
// state | meaning
// IDLE  | waiting for a valid M-ext op; fast-path div cases resolve here
// MUL   | one cycle for the inferred multiplier, result captured on exit
// DIV   | restoring shift-subtract, DIV_UNROLL quotient bits per cycle
// FIX   | apply quotient/remainder sign for signed divides
// DONE  | done_o pulse, result_o valid; EX advances
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DIV_UNROLL = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  funct3_t         funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int DIV_CYCLES = XLEN / DIV_UNROLL;
  localparam int CNT_W      = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]      state_q, state_d;
  funct3_t         funct3_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] rem_q, quot_q, divisor_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] result_q;

  logic            start_ok;
  logic            a_neg_in, b_neg_in;
  logic [XLEN-1:0] abs_a_in, abs_b_in;
  logic            b_zero, div_ovf;
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;

  logic              a_ext, b_ext;
  logic [2*XLEN-1:0] a_wide, b_wide, product;
  logic [XLEN-1:0]   mul_res;

  logic            a_neg_q, b_neg_q;
  logic [XLEN-1:0] fix_res;

  logic [XLEN-1:0] rem_chain  [DIV_UNROLL+1];
  logic [XLEN-1:0] quot_chain [DIV_UNROLL+1];

  assign start_ok = start_i & ~flush_i;

  // Signed divides work on magnitudes; signs are re-applied in FIX.
  assign a_neg_in = is_signed_div(funct3_i) & op_a_i[XLEN-1];
  assign b_neg_in = is_signed_div(funct3_i) & op_b_i[XLEN-1];
  assign abs_a_in = a_neg_in ? -op_a_i : op_a_i;
  assign abs_b_in = b_neg_in ? -op_b_i : op_b_i;
  assign b_zero   = (op_b_i == '0);
  assign div_ovf  = (op_a_i == MIN_INT) && (op_b_i == '1);

  // Divide-by-zero and MIN/-1 overflow bypass the iterative divider.
  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    case (funct3_i)
      F3_DIV: begin
        if (b_zero) begin
          fast_hit = 1'b1;
          fast_res = '1;
        end else if (div_ovf) begin
          fast_hit = 1'b1;
          fast_res = MIN_INT;
        end
      end
      F3_DIVU: begin
        if (b_zero) begin
          fast_hit = 1'b1;
          fast_res = '1;
        end
      end
      F3_REM: begin
        if (b_zero) begin
          fast_hit = 1'b1;
          fast_res = op_a_i;
        end else if (div_ovf) begin
          fast_hit = 1'b1;
          fast_res = '0;
        end
      end
      F3_REMU: begin
        if (b_zero) begin
          fast_hit = 1'b1;
          fast_res = op_a_i;
        end
      end
      default: ;
    endcase
  end

  // Operand extension per multiply flavour.
  always_comb begin
    a_ext = 1'b0;
    b_ext = 1'b0;
    case (funct3_q)
      F3_MUL, F3_MULH: begin
        a_ext = a_q[XLEN-1];
        b_ext = b_q[XLEN-1];
      end
      F3_MULHSU: a_ext = a_q[XLEN-1];
      F3_MULHU:  ;
      default:   ;
    endcase
  end

  // Extending both operands to 2*XLEN keeps the low 2*XLEN product bits exact
  // for every signedness combination; left as a plain '*' for DSP mapping.
  assign a_wide  = {{XLEN{a_ext}}, a_q};
  assign b_wide  = {{XLEN{b_ext}}, b_q};
  assign product = a_wide * b_wide;
  assign mul_res = (funct3_q == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  assign rem_chain[0]  = rem_q;
  assign quot_chain[0] = quot_q;

  for (genvar i = 0; i < DIV_UNROLL; i++) begin : g_div_step
    muldiv_sequencer_div_step #(.XLEN(XLEN)) u_div_step (
      .rem       (rem_chain[i]),
      .quot      (quot_chain[i]),
      .divisor   (divisor_q),
      .rem_next  (rem_chain[i+1]),
      .quot_next (quot_chain[i+1])
    );
  end

  // Sign correction: quotient negative when operand signs differ, remainder follows dividend.
  assign a_neg_q = is_signed_div(funct3_q) & a_q[XLEN-1];
  assign b_neg_q = is_signed_div(funct3_q) & b_q[XLEN-1];

  always_comb begin
    fix_res = quot_q;
    case (funct3_q)
      F3_REM, F3_REMU: fix_res = a_neg_q ? -rem_q : rem_q;
      default:         fix_res = (a_neg_q ^ b_neg_q) ? -quot_q : quot_q;
    endcase
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          if (is_div_op(funct3_i)) state_d = fast_hit ? ST_DONE : ST_DIV;
          else                     state_d = ST_MUL;
        end
      end
      ST_MUL:  state_d = ST_DONE;
      ST_DIV:  if (cnt_q == CNT_LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Operand capture and divider iteration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      funct3_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            funct3_q  <= funct3_i;
            a_q       <= op_a_i;
            b_q       <= op_b_i;
            rem_q     <= '0;
            quot_q    <= abs_a_in;
            divisor_q <= abs_b_in;
            cnt_q     <= '0;
          end
        end
        ST_DIV: begin
          rem_q  <= rem_chain[DIV_UNROLL];
          quot_q <= quot_chain[DIV_UNROLL];
          cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result register only changes on entry to DONE, so it holds across idle cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= '0;
    end else if (state_d == ST_DONE) begin
      case (state_q)
        ST_IDLE: result_q <= fast_res;
        ST_MUL:  result_q <= mul_res;
        ST_FIX:  result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign stall_o  = rst_ni & (((state_q == ST_IDLE) & start_ok) |
                              (state_q == ST_MUL) | (state_q == ST_DIV) | (state_q == ST_FIX));
  assign done_o   = (state_q == ST_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (XLEN=32, DIV_UNROLL=1).
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  f3;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int n_eval;
  int n_fail;
  int seen_done;
  int seen_stall;

  muldiv_sequencer #(.XLEN(32), .DIV_UNROLL(1)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .funct3_i (f3),
    .op_a_i   (a),
    .op_b_i   (b),
    .flush_i  (flush),
    .stall_o  (stall),
    .done_o   (done),
    .result_o (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", name, obs, exp);
    end
  endtask

  // Issue one op at a negedge (cycle 0), hold start until done, check latency,
  // stall length, result and that the result holds one cycle later.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] opa,
                        input logic [31:0] opb, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int stall_cnt;
    lat = 0;
    stall_cnt = 0;
    @(negedge clk);
    f3 = f;
    a = opa;
    b = opb;
    start = 1'b1;
    #1;
    if (stall) stall_cnt++;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        check({name, " stall at done"}, {31'b0, stall}, 32'h0);
        check({name, " result"}, result, exp_res);
        start = 1'b0;
      end else if (stall) begin
        stall_cnt++;
      end
    end
    start = 1'b0;
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " stall cycles"}, 32'(stall_cnt), 32'(exp_lat));
    @(negedge clk);
    check({name, " result hold"}, result, exp_res);
    check({name, " done pulse"}, {31'b0, done}, 32'h0);
  endtask

  initial begin
    n_eval = 0;
    n_fail = 0;
    start = 1'b0;
    flush = 1'b0;
    f3 = F3_MUL;
    a = '0;
    b = '0;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    check("reset stall", {31'b0, stall}, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset result", result, 32'h0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle stall", {31'b0, stall}, 32'h0);

    run_op("MUL 7*-3",        F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    run_op("MULH min*min",    F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run_op("MULHU max*max",   F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("MULHSU -1*max",   F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_op("DIV -7/2",        F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
    run_op("REM -7/2",        F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
    run_op("DIVU 5/0",        F3_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1);
    run_op("REMU 5/0",        F3_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1);
    run_op("DIV ovf",         F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf",         F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("DIVU 100/7",      F3_DIVU,   32'd100,       32'd7,         32'd14,        34);
    run_op("REMU 100/7",      F3_REMU,   32'd100,       32'd7,         32'd2,         34);

    // Flush a divide at cycle 10.
    @(negedge clk);
    f3 = F3_DIV;
    a = 32'hFFFF_FFF9;
    b = 32'h0000_0002;
    start = 1'b1;
    repeat (10) @(negedge clk);
    check("flush stall before", {31'b0, stall}, 32'h1);
    flush = 1'b1;
    @(negedge clk);
    check("flush no done", {31'b0, done}, 32'h0);
    check("flush result kept", result, 32'd2);
    start = 1'b0;
    flush = 1'b0;
    #1;
    check("flush idle stall", {31'b0, stall}, 32'h0);
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      seen_done += int'(done);
    end
    check("flush no late done", 32'(seen_done), 32'h0);
    run_op("MUL 3*4 after flush", F3_MUL, 32'd3, 32'd4, 32'd12, 2);

    // Asynchronous reset during a divide.
    @(negedge clk);
    f3 = F3_DIVU;
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset stall", {31'b0, stall}, 32'h0);
    check("midreset done", {31'b0, done}, 32'h0);
    check("midreset result", result, 32'h0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    seen_stall = 0;
    repeat (5) begin
      @(negedge clk);
      seen_done += int'(done);
      seen_stall += int'(stall);
    end
    check("post-reset no done", 32'(seen_done), 32'h0);
    check("post-reset no stall", 32'(seen_stall), 32'h0);

    run_op("DIV 100/-7 after reset", F3_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
    run_op("MUL 0x12345678*16",      F3_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
